// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and default operand width for mult_seq.
package mult_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam int DEF_WIDTH = 16;
endpackage

// File: rtl/mult_step.sv
// mult_step: one shift-add step of the sequential multiplier.
module mult_step #(
   parameter int WIDTH = 16
) (
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [2*WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic [2*WIDTH-1:0] o_acc,
   output logic [2*WIDTH-1:0] o_a,
   output logic [WIDTH-1:0]   o_b
);
   always_comb begin
      o_acc = i_b[0] ? i_acc + i_a : i_acc;
      o_a   = i_a << 1;
      o_b   = i_b >> 1;
   end
endmodule

// File: rtl/mult_seq.sv
// mult_seq: unsigned shift-add multiplier, WIDTH cycles per product.
// Optional ovf output when MULT_SEQ_OVF_EN is defined.
module mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic [WIDTH-1:0] product,
`ifdef MULT_SEQ_OVF_EN
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 1);

   state_t               r_state, w_state_nxt;
   logic [2*WIDTH-1:0]   r_acc, r_a, w_acc, w_a;
   logic [WIDTH-1:0]     r_b, w_b, r_product;
   logic [CW-1:0]        r_cnt;
   logic                 w_last, w_accept;

   assign w_last   = r_cnt == CW'(WIDTH - 1);
   assign w_accept = r_state == IDLE && start;
   assign product  = r_product;

   mult_step #(.WIDTH(WIDTH)) u_step (
      .i_acc(r_acc),
      .i_a  (r_a),
      .i_b  (r_b),
      .o_acc(w_acc),
      .o_a  (w_a),
      .o_b  (w_b)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = start ? CALC : IDLE;
         CALC:    w_state_nxt = w_last ? DONE : CALC;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = r_state != IDLE;
      done = r_state == DONE;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_acc     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_acc <= '0;
         r_a   <= {{WIDTH{1'b0}}, multiplicand};
         r_b   <= multiplier;
         r_cnt <= '0;
      end else if (r_state == CALC) begin
         r_acc <= w_acc;
         r_a   <= w_a;
         r_b   <= w_b;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) r_product <= w_acc[WIDTH-1:0];
      end
   end

`ifdef MULT_SEQ_OVF_EN
   // The final step's upper half decides overflow, captured with product.
   always_ff @(posedge CLK) begin
      if (!RST_N)                      ovf <= 1'b0;
      else if (r_state == CALC && w_last) ovf <= |w_acc[2*WIDTH-1:WIDTH];
   end
`endif
endmodule
